sm3_msg_expand: RTL and testbench
=================================

Name: sm3_msg_expand

Overview:
- Sequencer for the SM3 message expansion.
- Accepts one 512-bit padded message block and streams W_j and W'_j = W_j ^ W_(j+4), for j = 0..NUM_ROUNDS-1, one pair per handshake to the compression round logic.
- Holds a 16-word sliding window and computes one new expanded word per accepted beat through fixed 32-bit left rotations.
- Sits between the block padder and the compression core.

Parameters:
- NUM_ROUNDS, 64, number of (W_j, W'_j) pairs emitted per block. Legal range is 16..64.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- start_in  input  1  block strobe. Sampled only when ready_out=1.
- block_in  input  512  padded block. Bits [511:480] = W_0, down to [31:0] = W_15 (big-endian words).
- ready_out  output  1  idle and able to accept start_in.
- w_valid_out  output  1  the current W/W' pair is valid.
- w_ready_in  input  1  downstream accepts the pair.
- w_out  output  32  W_j.
- wp_out  output  32  W'_j.
- index_out  output  6  j.
- last_out  output  1  high together with the pair j = NUM_ROUNDS-1.
- done_out  output  1  one-cycle pulse after the last pair transfers.

Behaviour:
- Reset values: ready_out=1, w_valid_out=0, last_out=0, done_out=0, index_out=0. Window registers cleared, so w_out=0 and wp_out=0. State is IDLE.
- Reset is asynchronous, so asserting it mid-block aborts immediately with no flush. After release, the block waits for a new start_in.
- States: IDLE and RUN.
- IDLE -> RUN:
  - Occurs on start_in=1 while in IDLE.
  - block_in loads into window win[0..15] (win[0]=W_0) on that edge.
  - The counter is cleared.
  - w_valid_out rises the next cycle. Latency from start to first valid pair is 1 cycle.
- RUN outputs, all driven combinationally from registers:
  - w_out = win[0].
  - wp_out = win[0] ^ win[4].
  - index_out = cnt.
  - w_valid_out = 1.
  - last_out = (cnt == NUM_ROUNDS-1).
- Transfer occurs when w_valid_out & w_ready_in. On a transfer:
  - win shifts down one: win[i] <= win[i+1].
  - win[15] <= N, where N = P1(win[0] ^ win[7] ^ ROTL(win[13],15)) ^ ROTL(win[3],7) ^ win[10].
  - P1(x) = x ^ ROTL(x,15) ^ ROTL(x,23).
  - cnt increments.
- Backpressure: while w_ready_in=0, the window, cnt and all outputs hold stable. w_valid_out never drops once raised until the last transfer.
- Word generation:
  - N is computed on every transfer, including j >= 52. Words W_68 and beyond enter the window but are never emitted as w_out.
  - wp_out for j <= 63 only ever uses W_0..W_67.
- Transfer with last_out=1:
  - State returns to IDLE and w_valid_out goes to 0 next cycle.
  - done_out pulses high for exactly that next cycle.
  - ready_out returns to 1 in the same cycle as the done_out pulse.
- start_in while in RUN is ignored, including the cycle of the last transfer. The earliest new start is the cycle ready_out=1.
- Arithmetic: all operations are XOR and constant rotations, modulo 32 bits. There are no adders. Rotations are left-rotations by constant amounts.
- The counter is 6 bits wide and saturates logically at NUM_ROUNDS-1, so there is no wrap.

Decomposition:
- Shared package sm3_pkg holds:
  - word width (32).
  - rotation constants ROT_P1_A=15, ROT_P1_B=23, ROT_EXP_A=15, ROT_EXP_B=7.
  - SM3_ROUNDS=64.
  - state encoding IDLE/RUN.
- One combinational sub-module, sm3_expand_word. It takes inputs w_jm16, w_jm13, w_jm9, w_jm6, w_jm3 and outputs the new word, with P1 and the constant rotations inside it. The controller instantiates it once.

Test Plan:
- "abc" block (61626380, fourteen zero words, 00000018), w_ready_in=1 -> first pair 1 cycle after start: j=0, w_out=61626380, wp_out=61626380. Then w_out at j=16 is 9092e200, j=18 is 000c0606, j=19 is 719c70ed. last_out is seen at j=63, done_out pulses 1 cycle later.
- All-zero block -> 64 pairs, all w_out=0 and wp_out=0. Exactly 64 transfers, then ready_out=1.
- Random w_ready_in (50%) on the "abc" block -> pairs identical to the no-stall run; outputs stable whenever valid=1 and ready=0. The total transfer count is 64.
- start_in pulsed at j=10 and on the last-transfer cycle -> both ignored, the sequence is unaffected. A start in the done_out cycle is accepted, with the first pair on the next cycle.
- rst_in asserted mid-block (j=30), asynchronously between edges -> w_valid_out=0 and ready_out=1 immediately. A new block then streams correctly from j=0.
- Back-to-back blocks (second start in the done_out cycle) -> the second block's W_0 appears 1 cycle later. There is no mixing of window contents.

Source files
------------

// File: rtl/sm3_pkg.sv
// Shared constants, state encoding and rotation helpers for the SM3 message expansion.
package sm3_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned ROT_P1_A   = 15;
    localparam int unsigned ROT_P1_B   = 23;
    localparam int unsigned ROT_EXP_A  = 15;
    localparam int unsigned ROT_EXP_B  = 7;
    localparam int unsigned SM3_ROUNDS = 64;

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] x,
                                               input int unsigned n);
        return (x << n) | (x >> (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] p1(input logic [WORD_W-1:0] x);
        return x ^ rotl(x, ROT_P1_A) ^ rotl(x, ROT_P1_B);
    endfunction

endpackage

// File: rtl/sm3_expand_word.sv
// Combinational SM3 expansion step: W_j from W_(j-16), W_(j-13), W_(j-9), W_(j-6), W_(j-3).
module sm3_expand_word
    import sm3_pkg::*;
(
    input  logic [WORD_W-1:0] w_jm16,
    input  logic [WORD_W-1:0] w_jm13,
    input  logic [WORD_W-1:0] w_jm9,
    input  logic [WORD_W-1:0] w_jm6,
    input  logic [WORD_W-1:0] w_jm3,
    output logic [WORD_W-1:0] w_new
);

    logic [WORD_W-1:0] w_p1_in;

    assign w_p1_in = w_jm16 ^ w_jm9 ^ rotl(w_jm3, ROT_EXP_A);
    assign w_new   = p1(w_p1_in) ^ rotl(w_jm13, ROT_EXP_B) ^ w_jm6;

endmodule

// File: rtl/sm3_msg_expand.sv
// SM3 message expansion sequencer: loads a 512-bit block into a 16-word window and
// streams (W_j, W_j ^ W_(j+4)) pairs over a valid/ready handshake.
module sm3_msg_expand
    import sm3_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = SM3_ROUNDS
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [16*WORD_W-1:0]  block_in,
    output logic                  ready_out,
    output logic                  w_valid_out,
    input  logic                  w_ready_in,
    output logic [WORD_W-1:0]     w_out,
    output logic [WORD_W-1:0]     wp_out,
    output logic [5:0]            index_out,
    output logic                  last_out,
    output logic                  done_out
);

    localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

    state_e            r_state;
    state_e            w_state_next;
    logic [WORD_W-1:0] r_win [16];
    logic [5:0]        r_cnt;
    logic              r_done;

    logic              w_start;
    logic              w_xfer;
    logic              w_last;
    logic [WORD_W-1:0] w_new;

    sm3_expand_word u_expand_word (
        .w_jm16 (r_win[0]),
        .w_jm13 (r_win[3]),
        .w_jm9  (r_win[7]),
        .w_jm6  (r_win[10]),
        .w_jm3  (r_win[13]),
        .w_new  (w_new)
    );

    assign w_start = (r_state == StIdle) && start_in;
    assign w_xfer  = (r_state == StRun) && w_ready_in;
    assign w_last  = (r_state == StRun) && (r_cnt == LAST_IDX);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: if (start_in) w_state_next = StRun;
            StRun:  if (w_xfer && w_last) w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            for (int i = 0; i < 16; i++) r_win[i] <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_xfer && w_last;
            if (w_start) begin
                // win[0] takes the most significant word of the block
                for (int i = 0; i < 16; i++) r_win[i] <= block_in[(15-i)*WORD_W +: WORD_W];
                r_cnt <= '0;
            end else if (w_xfer) begin
                for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
                r_win[15] <= w_new;
                if (!w_last) r_cnt <= r_cnt + 6'd1;
            end
        end
    end

    assign ready_out   = (r_state == StIdle);
    assign w_valid_out = (r_state == StRun);
    assign w_out       = r_win[0];
    assign wp_out      = r_win[0] ^ r_win[4];
    assign index_out   = r_cnt;
    assign last_out    = w_last;
    assign done_out    = r_done;

endmodule

// File: tb/tb_sm3_msg_expand.sv
// Self-checking bench for sm3_msg_expand against an array-based SM3 expansion model.
module tb_sm3_msg_expand;

    localparam int NR = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [511:0] blk = '0;
    logic         w_ready = 1'b0;
    logic         ready, valid, last, done;
    logic [31:0]  w, wp;
    logic [5:0]   idx;

    int checks = 0;
    int errors = 0;
    logic [31:0] ref_w [68];

    always #5 clk = ~clk;

    sm3_msg_expand #(.NUM_ROUNDS(NR)) dut (
        .clk_in      (clk),
        .rst_in      (rst),
        .start_in    (start),
        .block_in    (blk),
        .ready_out   (ready),
        .w_valid_out (valid),
        .w_ready_in  (w_ready),
        .w_out       (w),
        .wp_out      (wp),
        .index_out   (idx),
        .last_out    (last),
        .done_out    (done)
    );

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} << n;
        return d[63:32];
    endfunction

    function automatic void gen_model(input logic [511:0] b);
        logic [31:0] x;
        for (int i = 0; i < 16; i++) ref_w[i] = b[511-32*i -: 32];
        for (int j = 16; j < 68; j++) begin
            x = ref_w[j-16] ^ ref_w[j-9] ^ rl(ref_w[j-3], 15);
            ref_w[j] = (x ^ rl(x, 15) ^ rl(x, 23)) ^ rl(ref_w[j-13], 7) ^ ref_w[j-6];
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Start a block at the current point (1 time unit after a rising edge) and follow it.
    task automatic stream(input logic [511:0] b, input bit stall, input bit poke,
                          input bit is_abc, input int abort_j);
        int j;
        int cyc;
        gen_model(b);
        blk = b;
        chk("ready_before_start", 32'(ready), 32'd1);
        start = 1'b1;
        w_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        blk = {16{$urandom()}};
        j = 0;
        cyc = 0;
        while (j < NR && cyc < 1000) begin
            if (j == abort_j) begin
                #2 rst = 1'b1;
                #1;
                chk("abort_valid", 32'(valid), 32'd0);
                chk("abort_ready", 32'(ready), 32'd1);
                chk("abort_index", 32'(idx), 32'd0);
                chk("abort_w", w, 32'd0);
                #1 rst = 1'b0;
                w_ready = 1'b0;
                return;
            end
            chk("valid", 32'(valid), 32'd1);
            chk("index", 32'(idx), 32'(j));
            chk("w", w, ref_w[j]);
            chk("wp", wp, ref_w[j] ^ ref_w[j+4]);
            chk("last", 32'(last), 32'(j == NR - 1));
            chk("done_low", 32'(done), 32'd0);
            if (is_abc && j == 16) chk("abc_w16", w, 32'h9092e200);
            if (is_abc && j == 18) chk("abc_w18", w, 32'h000c0606);
            if (is_abc && j == 19) chk("abc_w19", w, 32'h719c70ed);
            w_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            start = poke && (j == 10 || j == NR - 1);
            @(posedge clk); #1;
            start = 1'b0;
            if (w_ready) j++;
            cyc++;
        end
        chk("transfers", 32'(j), 32'(NR));
        chk("done_pulse", 32'(done), 32'd1);
        chk("ready_after", 32'(ready), 32'd1);
        chk("valid_after", 32'(valid), 32'd0);
    endtask

    logic [511:0] abc_blk;
    logic [511:0] rnd_blk;

    initial begin
        abc_blk = {32'h61626380, {14{32'h0}}, 32'h00000018};
        #12;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_last", 32'(last), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_index", 32'(idx), 32'd0);
        chk("rst_w", w, 32'd0);
        chk("rst_wp", wp, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        stream(abc_blk, 1'b0, 1'b0, 1'b1, -1);
        @(posedge clk); #1;
        stream('0, 1'b0, 1'b0, 1'b0, -1);
        @(posedge clk); #1;
        stream(abc_blk, 1'b1, 1'b0, 1'b1, -1);
        @(posedge clk); #1;
        // Pokes at j=10 and the last transfer, then a back-to-back start in the done cycle
        stream(abc_blk, 1'b0, 1'b1, 1'b1, -1);
        for (int i = 0; i < 16; i++) rnd_blk[32*i +: 32] = $urandom();
        stream(rnd_blk, 1'b0, 1'b0, 1'b0, -1);
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) rnd_blk[32*i +: 32] = $urandom();
        stream(rnd_blk, 1'b1, 1'b0, 1'b0, 30);
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(ready), 32'd1);
        for (int i = 0; i < 16; i++) rnd_blk[32*i +: 32] = $urandom();
        stream(rnd_blk, 1'b1, 1'b0, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
